// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_sequencer_pkg;

    // Boot fetch PC; the sequencer aligns it down to a line boundary.
    localparam logic [31:0] resetVector = 32'h0000_1004;

    // One fetch line is 128 bits.
    localparam int LINE_BYTES = 16;

    // Buffered line: its aligned address plus the raw line data.
    typedef struct packed {
        logic [31:0]  address;
        logic [127:0] data;
    } FetchLine_;

endpackage

// File: rtl/fetch_line_buffer.sv
// Small circular FIFO of fetch lines with synchronous clear.
// Latency: a pushed line is visible at the head one cycle later (no bypass).
// Backpressure: pop is ignored when empty; push is dropped when full unless a pop frees the slot.
module fetch_line_buffer
    import fetch_sequencer_pkg::*;
#(
    parameter int DEPTH = 2
)
(
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       push,
    input  FetchLine_  pushLine,
    input  logic       pop,
    output FetchLine_  headLine,
    output logic [2:0] count,
    output logic       empty,
    output logic       full
);

    localparam int              PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST   = PTR_W'(DEPTH - 1);
    localparam logic [2:0]      DEPTH_C = 3'(DEPTH);

    FetchLine_        entries [DEPTH];
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] wrPtr;
    logic             doPush;
    logic             doPop;

    // Pointers wrap at DEPTH so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign empty    = (count == 3'd0);
    assign full     = (count == DEPTH_C);
    assign doPop    = pop && !empty;
    assign doPush   = push && (!full || doPop);
    assign headLine = entries[rdPtr];

    // Occupancy and pointer bookkeeping; clear discards every entry at once.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= 3'd0;
        end else begin
            if (doPush) wrPtr <= nextPtr(wrPtr);
            if (doPop)  rdPtr <= nextPtr(rdPtr);
            count <= count + {2'b00, doPush} - {2'b00, doPop};
        end
    end

    // Line storage is pure datapath and needs no reset.
    always_ff @(posedge clock) begin
        if (doPush) entries[wrPtr] <= pushLine;
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Issues aligned 128-bit line fetches, drops stale responses after redirect, buffers live lines.
// Latency: response to lineValid is one cycle; redirect to first new request is one cycle.
// Backpressure: issue is credit-limited by in-flight count plus buffer occupancy; responses never stall.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2,
    parameter int BUFFER_DEPTH    = 2
)
(
    input  logic         clock,
    input  logic         reset,
    input  logic         redirect,
    input  logic [31:0]  redirectVector,
    output logic         requestValid,
    output logic [31:0]  requestAddress,
    input  logic         requestReady,
    input  logic         responseValid,
    input  logic [127:0] responseData,
    output logic         lineValid,
    output logic [31:0]  lineAddress,
    output logic [127:0] lineData,
    input  logic         lineReady
);

    localparam logic [31:0] LINE_STEP  = 32'(LINE_BYTES);
    localparam logic [31:0] LINE_MASK  = ~32'(LINE_BYTES - 1);
    localparam logic [31:0] RESET_LINE = resetVector & LINE_MASK;
    localparam logic [2:0]  MAX_OUT    = 3'(MAX_OUTSTANDING);
    localparam logic [3:0]  DEPTH_C    = 4'(BUFFER_DEPTH);

    logic [31:0] fetchAddress;
    logic [31:0] returnAddress;
    logic [31:0] redirectLine;
    logic [2:0]  outstanding;
    logic [2:0]  dropCount;
    logic [2:0]  count;
    logic [3:0]  creditUse;
    logic        requestFire;
    logic        livePush;
    logic        bufPop;
    logic        bufEmpty;
    logic        bufFull;
    FetchLine_   pushLine;
    FetchLine_   headLine;

    // Live in-flight requests plus buffered lines must fit in the buffer,
    // because a response can never be refused.
    assign creditUse      = {1'b0, outstanding - dropCount} + {1'b0, count};
    assign requestValid   = !reset && !redirect && (outstanding < MAX_OUT) && (creditUse < DEPTH_C);
    assign requestAddress = fetchAddress;
    assign requestFire    = requestValid && requestReady;
    assign redirectLine   = redirectVector & LINE_MASK;

    // A response is live only when no stale requests remain ahead of it and
    // no redirect is flushing this cycle.
    assign livePush = responseValid && !redirect && (dropCount == 3'd0);
    assign pushLine = '{address: returnAddress, data: responseData};
    assign bufPop   = lineValid && lineReady && !redirect;

    assign lineValid   = !reset && !bufEmpty;
    assign lineAddress = headLine.address;
    assign lineData    = headLine.data;

    // Address, credit and stale-drop tracking; redirect marks all remaining in-flight requests stale.
    always_ff @(posedge clock) begin
        if (reset) begin
            fetchAddress  <= RESET_LINE;
            returnAddress <= RESET_LINE;
            outstanding   <= 3'd0;
            dropCount     <= 3'd0;
        end else begin
            outstanding <= outstanding + {2'b00, requestFire} - {2'b00, responseValid};
            if (redirect) begin
                fetchAddress  <= redirectLine;
                returnAddress <= redirectLine;
                dropCount     <= outstanding - {2'b00, responseValid};
            end else begin
                if (requestFire) fetchAddress <= fetchAddress + LINE_STEP;
                if (responseValid) begin
                    if (dropCount != 3'd0) dropCount <= dropCount - 3'd1;
                    else                   returnAddress <= returnAddress + LINE_STEP;
                end
            end
        end
    end

    fetch_line_buffer #(
        .DEPTH(BUFFER_DEPTH)
    ) u_buffer (
        .clock    (clock),
        .reset    (reset),
        .clear    (redirect),
        .push     (livePush),
        .pushLine (pushLine),
        .pop      (bufPop),
        .headLine (headLine),
        .count    (count),
        .empty    (bufEmpty),
        .full     (bufFull)
    );

    // Memory must never return more lines than were requested.
    a_no_orphan_response: assert property (@(posedge clock) disable iff (reset)
        responseValid |-> (outstanding != 3'd0));

    // Stale requests are a subset of in-flight requests.
    a_drop_bounded: assert property (@(posedge clock) disable iff (reset)
        dropCount <= outstanding);

    // Credit accounting guarantees room for every live response.
    a_no_overflow: assert property (@(posedge clock) disable iff (reset)
        livePush |-> !bufFull);

endmodule
